// File: rtl/video_timing_pkg.sv
// Shared types and default constants for the raster timing / noise generator.
// Free-running block with no backpressure; every consumer samples on ce_pix.
package video_timing_pkg;

  typedef enum logic [1:0] {
    NC_WHITE = 2'd0,
    NC_RED   = 2'd1,
    NC_GREEN = 2'd2,
    NC_BLUE  = 2'd3
  } noise_col_e;

  localparam int DEF_CE_DIV   = 4;
  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 32;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACT_N  = 240;
  localparam int DEF_V_ACT_P  = 288;
  localparam int DEF_V_FP     = 3;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP_N   = 16;
  localparam int DEF_V_BP_P   = 18;

  localparam int CNT_W   = 9;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Right-shifting Galois form of x^24+x^23+x^22+x^17+1.
  localparam logic [23:0] LFSR_SEED = 24'h000001;
  localparam logic [23:0] LFSR_TAPS = 24'hE10000;

endpackage

// File: rtl/video_timing_gen_lfsr24.sv
// 24-bit Galois LFSR noise source; advances one state per cycle with step high.
// Output is the current register state (zero latency), no backpressure.
module lfsr24
  import video_timing_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        step,
  output logic [23:0] q
);

  logic [23:0] r_state;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= LFSR_SEED;
    end else if (step) begin
      r_state <= {1'b0, r_state[23:1]} ^ (r_state[0] ? LFSR_TAPS : 24'h000000);
    end
  end

  assign q = r_state;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing + RGB888 noise generator: sync/blank/de decode is zero latency vs hcount/vcount,
// r/g/b lag de by one pixel; free-running, no backpressure.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CE_DIV   = DEF_CE_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACT_N  = DEF_V_ACT_N,
  parameter int V_ACT_P  = DEF_V_ACT_P,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP_N   = DEF_V_BP_N,
  parameter int V_BP_P   = DEF_V_BP_P
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       pal,
  input  logic [1:0] noise_sel,
  output logic       ce_pix,
  output logic       hs,
  output logic       vs,
  output logic       hblank,
  output logic       vblank,
  output logic       de,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic [8:0] hcount,
  output logic [8:0] vcount,
  output logic       frame_start
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL_N = V_ACT_N + V_FP + V_SYNC + V_BP_N;
  localparam int V_TOTAL_P = V_ACT_P + V_FP + V_SYNC + V_BP_P;
  localparam int DIV_W     = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  if (CE_DIV < 1 || H_TOTAL > CNT_MAX || V_TOTAL_N > CNT_MAX || V_TOTAL_P > CNT_MAX) begin : g_bad_params
    $fatal(1, "video_timing_gen: CE_DIV must be >= 1 and raster totals must fit 9-bit counters");
  end

  logic [DIV_W-1:0] r_div;
  logic [8:0]       r_hcount;
  logic [8:0]       r_vcount;
  logic             r_pal;
  noise_col_e       r_nsel;
  logic [7:0]       r_col_r;
  logic [7:0]       r_col_g;
  logic [7:0]       r_col_b;
  logic             r_frame_start;

  logic             w_ce;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_frame_wrap;
  logic [8:0]       w_v_act;
  logic [8:0]       w_v_sync_s;
  logic [8:0]       w_v_sync_e;
  logic [8:0]       w_v_last_idx;
  logic             w_hblank;
  logic             w_vblank;
  logic             w_de;
  logic [23:0]      w_lfsr;
  logic [7:0]       w_n;
  logic [7:0]       w_r;
  logic [7:0]       w_g;
  logic [7:0]       w_b;
  logic             w_lfsr_unused;

  assign w_ce = (r_div == DIV_W'(CE_DIV - 1));

  always_ff @(posedge clk_sys) begin
    if (reset || w_ce) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Vertical geometry follows the latched mode so a mid-frame pal change waits for the wrap.
  assign w_v_act      = r_pal ? 9'(V_ACT_P) : 9'(V_ACT_N);
  assign w_v_sync_s   = r_pal ? 9'(V_ACT_P + V_FP) : 9'(V_ACT_N + V_FP);
  assign w_v_sync_e   = r_pal ? 9'(V_ACT_P + V_FP + V_SYNC) : 9'(V_ACT_N + V_FP + V_SYNC);
  assign w_v_last_idx = r_pal ? 9'(V_TOTAL_P - 1) : 9'(V_TOTAL_N - 1);

  assign w_h_last     = (r_hcount == 9'(H_TOTAL - 1));
  assign w_v_last     = (r_vcount == w_v_last_idx);
  assign w_frame_wrap = w_ce && w_h_last && w_v_last;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (w_ce) begin
      if (w_h_last) begin
        r_hcount <= '0;
        r_vcount <= w_v_last ? 9'd0 : r_vcount + 9'd1;
      end else begin
        r_hcount <= r_hcount + 9'd1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset || w_frame_wrap) begin
      r_pal  <= pal;
      r_nsel <= noise_col_e'(noise_sel);
    end
  end

  assign w_hblank = (r_hcount >= 9'(H_ACTIVE));
  assign w_vblank = (r_vcount >= w_v_act);
  assign w_de     = !(w_hblank || w_vblank);

  lfsr24 u_lfsr (
    .clk_sys (clk_sys),
    .reset   (reset),
    .step    (w_ce && w_de),
    .q       (w_lfsr)
  );

  assign w_n           = w_lfsr[7:0];
  assign w_lfsr_unused = ^w_lfsr[23:8];

  always_comb begin
    w_r = 8'h00;
    w_g = 8'h00;
    w_b = 8'h00;
    case (r_nsel)
      NC_WHITE: begin
        w_r = w_n;
        w_g = w_n;
        w_b = w_n;
      end
      NC_RED:   w_r = w_n;
      NC_GREEN: w_g = w_n;
      NC_BLUE:  w_b = w_n;
      default:  w_r = 8'h00;
    endcase
  end

  // Colour is captured with the pixel's de, so blank pixels land as zero one pixel later.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_col_r       <= '0;
      r_col_g       <= '0;
      r_col_b       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_wrap;
      if (w_ce) begin
        r_col_r <= w_de ? w_r : 8'h00;
        r_col_g <= w_de ? w_g : 8'h00;
        r_col_b <= w_de ? w_b : 8'h00;
      end
    end
  end

  assign ce_pix      = w_ce;
  assign hblank      = w_hblank;
  assign vblank      = w_vblank;
  assign de          = w_de;
  assign hs          = (r_hcount >= 9'(H_ACTIVE + H_FP)) && (r_hcount < 9'(H_ACTIVE + H_FP + H_SYNC));
  assign vs          = (r_vcount >= w_v_sync_s) && (r_vcount < w_v_sync_e);
  assign r           = r_col_r;
  assign g           = r_col_g;
  assign b           = r_col_b;
  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: A = default timing (CE_DIV=4), B = CE_DIV=1 default raster,
// C = CE_DIV=1 with a 16-pixel line so full NTSC/PAL frames stay short.
module tb_video_timing_gen;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic       rst_a, pal_a, ce_a, hs_a, vs_a, hb_a, vb_a, de_a, fs_a;
  logic [1:0] nsel_a;
  logic [7:0] r_a, g_a, b_a;
  logic [8:0] hc_a, vc_a;

  logic       rst_b, pal_b, ce_b, hs_b, vs_b, hb_b, vb_b, de_b, fs_b;
  logic [1:0] nsel_b;
  logic [7:0] r_b, g_b, b_b;
  logic [8:0] hc_b, vc_b;

  logic       rst_c, pal_c, ce_c, hs_c, vs_c, hb_c, vb_c, de_c, fs_c;
  logic [1:0] nsel_c;
  logic [7:0] r_c, g_c, b_c;
  logic [8:0] hc_c, vc_c;

  video_timing_gen u_dut_a (
    .clk_sys(clk_sys), .reset(rst_a), .pal(pal_a), .noise_sel(nsel_a),
    .ce_pix(ce_a), .hs(hs_a), .vs(vs_a), .hblank(hb_a), .vblank(vb_a), .de(de_a),
    .r(r_a), .g(g_a), .b(b_a), .hcount(hc_a), .vcount(vc_a), .frame_start(fs_a)
  );

  video_timing_gen #(.CE_DIV(1)) u_dut_b (
    .clk_sys(clk_sys), .reset(rst_b), .pal(pal_b), .noise_sel(nsel_b),
    .ce_pix(ce_b), .hs(hs_b), .vs(vs_b), .hblank(hb_b), .vblank(vb_b), .de(de_b),
    .r(r_b), .g(g_b), .b(b_b), .hcount(hc_b), .vcount(vc_b), .frame_start(fs_b)
  );

  video_timing_gen #(.CE_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4)) u_dut_c (
    .clk_sys(clk_sys), .reset(rst_c), .pal(pal_c), .noise_sel(nsel_c),
    .ce_pix(ce_c), .hs(hs_c), .vs(vs_c), .hblank(hb_c), .vblank(vb_c), .de(de_c),
    .r(r_c), .g(g_c), .b(b_c), .hcount(hc_c), .vcount(vc_c), .frame_start(fs_c)
  );

  int n_cmp = 0;
  int n_err = 0;

  int          first_ce, t, rise0, rise1, ce_low, fs_cnt;
  int          vs_rises, hs_rises, vs_hi, vmax, vb_line, vs_line;
  logic        hs_prev, vs_prev, vb_prev, pend, exp_de, reached, wrapped, cur_pal;
  logic [7:0]  exp_n, exp_px;
  logic [23:0] m_a, m_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference Galois step for x^24+x^23+x^22+x^17+1 (bits 23,22,21,16 toggled on feedback).
  function automatic logic [23:0] lfsr_next(input logic [23:0] s);
    logic [23:0] n;
    n = {1'b0, s[23:1]};
    if (s[0]) n = n ^ 24'hE10000;
    return n;
  endfunction

  // One cycle of DUT C (ce every cycle): advance the noise model, optionally check colour.
  task automatic c_tick(input logic chk_col);
    logic       d;
    logic [7:0] e;
    d = (hc_c < 9'd8) && (vc_c < (cur_pal ? 9'd288 : 9'd240));
    e = m_c[7:0];
    if (chk_col) chk("c_de", de_c, d);
    if (d) m_c = lfsr_next(m_c);
    if (hc_c == 9'd15 && vc_c == (cur_pal ? 9'd311 : 9'd261)) cur_pal = pal_c;
    @(negedge clk_sys);
    if (chk_col) begin
      chk("c_red_r", r_c, d ? e : 8'h00);
      chk("c_red_g", g_c, 8'h00);
      chk("c_red_b", b_c, 8'h00);
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    pal_a = 1'b0; pal_b = 1'b0; pal_c = 1'b0;
    nsel_a = 2'd0; nsel_b = 2'd0; nsel_c = 2'd0;
    cur_pal = 1'b0;

    // Reset state on A after 5 cycles of reset.
    repeat (5) @(negedge clk_sys);
    chk("rst_hcount", hc_a, 0);
    chk("rst_vcount", vc_a, 0);
    chk("rst_r", r_a, 0);
    chk("rst_g", g_a, 0);
    chk("rst_b", b_a, 0);
    chk("rst_hs", hs_a, 0);
    chk("rst_vs", vs_a, 0);
    chk("rst_hblank", hb_a, 0);
    chk("rst_vblank", vb_a, 0);
    chk("rst_frame_start", fs_a, 0);
    chk("rst_ce_pix", ce_a, 0);

    rst_a = 1'b0;
    first_ce = 0;
    for (int k = 1; k <= 8; k++) begin
      if (ce_a) begin
        first_ce = k;
        break;
      end
      @(negedge clk_sys);
    end
    chk("a_first_ce_cycle", first_ce, 4);
    chk("a_first_ce_hcount", hc_a, 0);
    chk("a_first_ce_vcount", vc_a, 0);

    // Two lines on A: white noise per pixel against the model, hs spacing.
    m_a = 24'h000001;
    t = 0; rise0 = -1; rise1 = -1;
    hs_prev = hs_a;
    for (int c = 0; c < 3400 && rise1 < 0; c++) begin
      pend   = ce_a;
      exp_de = (hc_a < 9'd320);
      exp_n  = m_a[7:0];
      if (ce_a && exp_de) m_a = lfsr_next(m_a);
      @(negedge clk_sys);
      t++;
      if (pend) begin
        exp_px = exp_de ? exp_n : 8'h00;
        chk("a_pix_r", r_a, exp_px);
        chk("a_pix_g", g_a, exp_px);
        chk("a_pix_b", b_a, exp_px);
      end
      if (hs_a && !hs_prev) begin
        if (rise0 < 0) begin
          rise0 = t;
          chk("a_hs_rise_hcount", hc_a, 336);
          chk("a_hs_rise_hblank", hb_a, 1);
          chk("a_hs_rise_de", de_a, 0);
        end else begin
          rise1 = t;
        end
      end
      hs_prev = hs_a;
    end
    chk("a_hs_period", rise1 - rise0, 1664);

    // B: CE_DIV=1, run to (200,50), reset mid-line.
    rst_b = 1'b0;
    ce_low = 0; reached = 1'b0;
    for (int c = 0; c < 25000; c++) begin
      if (hc_b == 9'd200 && vc_b == 9'd50) begin
        reached = 1'b1;
        break;
      end
      if (!ce_b) ce_low++;
      @(negedge clk_sys);
    end
    chk("b_reach_200_50", reached, 1);
    chk("b_ce_always_high", ce_low, 0);
    chk("b_de_mid_frame", de_b, 1);
    rst_b = 1'b1;
    @(negedge clk_sys);
    chk("b_rst_hcount", hc_b, 0);
    chk("b_rst_vcount", vc_b, 0);
    chk("b_rst_frame_start", fs_b, 0);
    chk("b_rst_ce_pix", ce_b, 1);
    rst_b = 1'b0;
    fs_cnt = 0;
    repeat (5) begin
      @(negedge clk_sys);
      if (fs_b) fs_cnt++;
    end
    chk("b_no_fs_after_rst", fs_cnt, 0);
    chk("b_hcount_after_rst", hc_b, 5);

    // C: NTSC frame geometry.
    rst_c = 1'b0;
    m_c = 24'h000001;
    cur_pal = 1'b0;
    vs_rises = 0; hs_rises = 0; vs_hi = 0; fs_cnt = 0;
    vs_prev = vs_c; hs_prev = hs_c;
    for (int c = 0; c < 9000 && vs_rises < 2; c++) begin
      c_tick(1'b0);
      if (fs_c) begin
        fs_cnt++;
        chk("c_fs_hcount", hc_c, 0);
        chk("c_fs_vcount", vc_c, 0);
      end
      if (vs_rises == 1 && hs_c && !hs_prev) hs_rises++;
      if (vs_c && !vs_prev) begin
        vs_rises++;
        if (vs_rises == 1) chk("c_vs_start_line", vc_c, 243);
      end
      if (vs_rises == 1 && vs_c) vs_hi++;
      hs_prev = hs_c;
      vs_prev = vs_c;
    end
    chk("c_vs_rises_seen", vs_rises, 2);
    chk("c_hs_per_frame", hs_rises, 262);
    chk("c_vs_high_cycles", vs_hi, 48);
    chk("c_fs_pulses", fs_cnt, 1);

    // Switch to PAL + red mid-frame: current frame still ends at 261.
    reached = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (vc_c == 9'd100) begin
        reached = 1'b1;
        break;
      end
      c_tick(1'b0);
    end
    chk("c_reach_v100", reached, 1);
    pal_c = 1'b1;
    nsel_c = 2'd1;
    vmax = 0; wrapped = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (int'(vc_c) > vmax) vmax = int'(vc_c);
      c_tick(1'b0);
      if (hc_c == 9'd0 && vc_c == 9'd0) begin
        wrapped = 1'b1;
        break;
      end
    end
    chk("c_ntsc_last_line", vmax, 261);
    chk("c_wrap_seen", wrapped, 1);
    chk("c_wrap_frame_start", fs_c, 1);

    // Full PAL frame with red noise checked on every pixel.
    vmax = 0; vb_line = -1; vs_line = -1;
    vb_prev = vb_c; vs_prev = vs_c;
    for (int c = 0; c < 312 * 16; c++) begin
      if (int'(vc_c) > vmax) vmax = int'(vc_c);
      c_tick(1'b1);
      if (vb_c && !vb_prev && vb_line < 0) vb_line = int'(vc_c);
      if (vs_c && !vs_prev && vs_line < 0) vs_line = int'(vc_c);
      vb_prev = vb_c;
      vs_prev = vs_c;
    end
    chk("c_pal_last_line", vmax, 311);
    chk("c_pal_vblank_line", vb_line, 288);
    chk("c_pal_vs_line", vs_line, 291);
    chk("c_pal_end_hcount", hc_c, 0);
    chk("c_pal_end_vcount", vc_c, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
